// File: rtl/user_out_blinker.sv
// Stretches one-cycle event pulses into visible LED blinks, queuing pulses that arrive mid-blink.
// Optional sticky lost-event flag when USER_OUT_OVERFLOW_EN is defined.
module user_out_blinker #(
  parameter int ON_CYCLES  = 4,
  parameter int OFF_CYCLES = 2,
  parameter int PEND_W     = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pulse,
  output logic              led,
  output logic              busy,
  output logic [PEND_W-1:0] pending
`ifdef USER_OUT_OVERFLOW_EN
  ,
  output logic              overflow
`endif
);

  localparam int TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0]     T_ON   = TW'(ON_CYCLES);
  localparam logic [TW-1:0]     T_OFF  = TW'(OFF_CYCLES);
  localparam logic [TW-1:0]     T_ONE  = TW'(1);
  localparam logic [PEND_W-1:0] P_MAX  = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] P_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic            last_off;
  logic            enqueue;
  logic            dequeue;

  // The final OFF cycle is the only point where a queued or fresh event can start a new blink.
  assign last_off = (state == OFF) && (timer == T_ONE);
  assign enqueue  = pulse && (state != IDLE) && !last_off;
  assign dequeue  = last_off && !pulse && (pending != P_ZERO);

  // NOTE: led and busy are assigned alongside the state transition so they come straight
  // from flops; decoding them from state combinationally would work but could glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
      led   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pulse) begin
            state <= ON;
            timer <= T_ON;
            led   <= 1'b1;
            busy  <= 1'b1;
          end
        end
        ON: begin
          if (timer == T_ONE) begin
            state <= OFF;
            timer <= T_OFF;
            led   <= 1'b0;
          end else begin
            timer <= timer - T_ONE;
          end
        end
        OFF: begin
          if (timer != T_ONE) begin
            timer <= timer - T_ONE;
          end else if (pulse || (pending != P_ZERO)) begin
            state <= ON;
            timer <= T_ON;
            led   <= 1'b1;
          end else begin
            state <= IDLE;
            timer <= '0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
          led   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // enqueue and dequeue are mutually exclusive, so no simultaneous push/pop case exists.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else if (enqueue && (pending != P_MAX)) begin
      pending <= pending + 1'b1;
    end else if (dequeue) begin
      pending <= pending - 1'b1;
    end
  end

`ifdef USER_OUT_OVERFLOW_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (enqueue && (pending == P_MAX)) begin
      overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_user_out_blinker.sv
// Scoreboard bench for user_out_blinker: a phase-position model predicts outputs per edge.
// Overflow is compared only when USER_OUT_OVERFLOW_EN is defined.
module tb_user_out_blinker;

  localparam int ON_C  = 4;
  localparam int OFF_C = 2;
  localparam int PMAX  = 7;

  logic       clk = 1'b0;
  logic       reset;
  logic       pulse;
  logic       led;
  logic       busy;
  logic [2:0] pending;
  logic       overflow;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  user_out_blinker #(.ON_CYCLES(ON_C), .OFF_CYCLES(OFF_C), .PEND_W(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .pulse   (pulse),
    .led     (led),
    .busy    (busy),
    .pending (pending)
`ifdef USER_OUT_OVERFLOW_EN
    ,
    .overflow(overflow)
`endif
  );

`ifndef USER_OUT_OVERFLOW_EN
  assign overflow = 1'b0;
`endif

  typedef struct {
    logic       led;
    logic       busy;
    logic [2:0] pend;
    logic       ovf;
  } exp_t;

  exp_t sb[$];

  // Reference model: position inside the current blink period rather than state plus timer.
  bit m_active;
  int m_pos;
  int m_pend;
  bit m_ovf;

  // Observed statistics, gathered from the DUT and checked against fixed expectations.
  int  blinks;
  int  busy_run;
  int  last_busy_len;
  int  peak_pend;
  logic prev_led;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    blinks        = 0;
    busy_run      = 0;
    last_busy_len = 0;
    peak_pend     = 0;
  endtask

  task automatic model_edge(input logic p, input logic r);
    if (r) begin
      m_active = 0; m_pos = 0; m_pend = 0; m_ovf = 0;
    end else if (!m_active) begin
      if (p) begin m_active = 1; m_pos = 0; end
    end else if (m_pos == ON_C + OFF_C - 1) begin
      if (p) m_pos = 0;
      else if (m_pend > 0) begin m_pend--; m_pos = 0; end
      else begin m_active = 0; m_pos = 0; end
    end else begin
      m_pos++;
      if (p) begin
        if (m_pend == PMAX) m_ovf = 1;
        else m_pend++;
      end
    end
  endtask

  task automatic step(input logic p, input logic r);
    exp_t e;
    exp_t got;
    pulse = p;
    reset = r;
    model_edge(p, r);
    e.led  = m_active && (m_pos < ON_C);
    e.busy = m_active;
    e.pend = 3'(m_pend);
    e.ovf  = m_ovf;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    got = sb.pop_front();
    check("led",     int'(led),     int'(got.led));
    check("busy",    int'(busy),    int'(got.busy));
    check("pending", int'(pending), int'(got.pend));
`ifdef USER_OUT_OVERFLOW_EN
    check("overflow", int'(overflow), int'(got.ovf));
`endif
    if (led && !prev_led) blinks++;
    prev_led = led;
    if (busy) busy_run++;
    else if (busy_run != 0) begin last_busy_len = busy_run; busy_run = 0; end
    if (int'(pending) > peak_pend) peak_pend = int'(pending);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    pulse = 1'b0;
    reset = 1'b1;
    prev_led = 1'b0;
    m_active = 0; m_pos = 0; m_pend = 0; m_ovf = 0;
    clear_stats();
    @(negedge clk);

    // Reset state
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("rst_led", int'(led), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_pending", int'(pending), 0);

    // Single pulse after a few idle edges
    clear_stats();
    idle(3);
    step(1'b1, 1'b0);
    check("single_led_on", int'(led), 1);
    idle(12);
    check("single_blinks", blinks, 1);
    check("single_busy_len", last_busy_len, ON_C + OFF_C);
    check("single_peak", peak_pend, 0);

    // Three pulses on consecutive edges
    clear_stats();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    idle(25);
    check("triple_blinks", blinks, 3);
    check("triple_busy_len", last_busy_len, 3 * (ON_C + OFF_C));
    check("triple_peak", peak_pend, 2);
    check("triple_drained", int'(pending), 0);

    // Held pulse: one start, five queued, one replaces the consume, two queued, one dropped
    clear_stats();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    check("sat_peak", int'(pending), PMAX);
`ifdef USER_OUT_OVERFLOW_EN
    check("sat_overflow", int'(overflow), 1);
`endif
    idle(60);
    check("sat_blinks", blinks, 9);
    check("sat_busy_len", last_busy_len, 9 * (ON_C + OFF_C));
`ifdef USER_OUT_OVERFLOW_EN
    check("sat_overflow_sticky", int'(overflow), 1);
`endif

    // Pulse exactly on the final OFF cycle restarts with no idle gap
    clear_stats();
    step(1'b1, 1'b0);
    idle(ON_C + OFF_C - 1);
    check("edge_busy_before", int'(busy), 1);
    check("edge_led_before", int'(led), 0);
    step(1'b1, 1'b0);
    check("edge_led_restart", int'(led), 1);
    check("edge_busy_restart", int'(busy), 1);
    idle(12);
    check("edge_blinks", blinks, 2);
    check("edge_busy_len", last_busy_len, 2 * (ON_C + OFF_C));
    check("edge_peak", peak_pend, 0);

    // Reset mid-blink while events are queued
    clear_stats();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    begin
      int budget;
      budget = 200;
      while (!(m_pend == 3 && m_active && m_pos < ON_C) && budget > 0) begin
        step(1'b0, 1'b0);
        budget--;
      end
      check("reach_pend3_timeout", int'(budget > 0), 1);
    end
    check("pre_rst_led", int'(led), 1);
    check("pre_rst_pending", int'(pending), 3);
    step(1'b0, 1'b1);
    check("mid_rst_led", int'(led), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_pending", int'(pending), 0);
`ifdef USER_OUT_OVERFLOW_EN
    check("mid_rst_overflow", int'(overflow), 0);
`endif
    clear_stats();
    idle(20);
    check("post_rst_blinks", blinks, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
